// File: rtl/riscvibe_pkg.sv
// riscvibe_pkg: shared branch encodings and branch-unit FSM states.
package riscvibe_pkg;
  typedef enum logic [1:0] {
    BRANCH_NONE = 2'd0,
    BRANCH_COND = 2'd1,
    BRANCH_JAL  = 2'd2,
    BRANCH_JALR = 2'd3
  } branch_type_t;
  typedef enum logic [2:0] {
    BEQ  = 3'b000,
    BNE  = 3'b001,
    BLT  = 3'b100,
    BGE  = 3'b101,
    BLTU = 3'b110,
    BGEU = 3'b111
  } branch_op_t;
  typedef enum logic {S_IDLE, S_FLUSH} bu_state_t;
endpackage

// File: rtl/branch_compare.sv
// branch_compare: combinational condition evaluation for conditional branches.
module branch_compare
  import riscvibe_pkg::*;
(
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  branch_op_t  op,
  output logic        taken
);
  logic eq, lt, ltu;
  always_comb begin
    eq    = rs1 == rs2;
    lt    = $signed(rs1) < $signed(rs2);
    ltu   = rs1 < rs2;
    taken = op == BEQ  ? eq   :
            op == BNE  ? !eq  :
            op == BLT  ? lt   :
            op == BGE  ? !lt  :
            op == BLTU ? ltu  :
            op == BGEU ? !ltu : 1'b0;
  end
endmodule

// File: rtl/branch_unit.sv
// branch_unit: resolves EX-stage branches/jumps into a one-cycle redirect plus a counted squash window.
// Optional BRANCH_PERF_CNT_EN adds branch/taken/jump performance counters.
module branch_unit
  import riscvibe_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         ex_valid,
  input  branch_type_t ex_branch_type,
  input  branch_op_t   ex_branch_op,
  input  logic [31:0]  ex_pc,
  input  logic [31:0]  ex_imm,
  input  logic [31:0]  rs1_data,
  input  logic [31:0]  rs2_data,
  output logic         branch_taken,
  output branch_type_t branch_type,
  output logic [31:0]  branch_target,
  output logic [31:0]  jalr_target,
  output logic         flush,
  output logic         target_misaligned,
  output logic         busy
`ifdef BRANCH_PERF_CNT_EN
  ,
  output logic [31:0]  perf_branches,
  output logic [31:0]  perf_taken,
  output logic [31:0]  perf_jumps
`endif
);
  localparam logic [2:0] FC = 3'(FLUSH_CYCLES);
  bu_state_t    state_q, state_d;
  logic [2:0]   cnt_q, cnt_d;
  logic         cond_true, accept, want, mis, redirect, is_jump;
  logic [31:0]  br_tgt, jr_tgt, sel_tgt;
  logic         taken_q, flush_q, busy_q, mis_q;
  branch_type_t type_q;
  logic [31:0]  br_tgt_q, jr_tgt_q;

  branch_compare u_cmp (
    .rs1   (rs1_data),
    .rs2   (rs2_data),
    .op    (ex_branch_op),
    .taken (cond_true)
  );

  always_comb begin
    br_tgt   = ex_pc + ex_imm;
    jr_tgt   = (rs1_data + ex_imm) & ~32'd1;
    is_jump  = ex_branch_type == BRANCH_JAL || ex_branch_type == BRANCH_JALR;
    accept   = ex_valid && state_q == S_IDLE;
    want     = accept && (is_jump || (ex_branch_type == BRANCH_COND && cond_true));
    sel_tgt  = ex_branch_type == BRANCH_JALR ? jr_tgt : br_tgt;
    mis      = want && sel_tgt[1:0] != 2'b00;
    redirect = want && !mis;
    state_d  = state_q == S_IDLE ? (redirect ? S_FLUSH : S_IDLE) : (cnt_q <= 3'd1 ? S_IDLE : S_FLUSH);
    cnt_d    = state_q == S_IDLE ? (redirect ? FC : 3'd0) : cnt_q - 3'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 3'd0;
      taken_q  <= 1'b0;
      type_q   <= BRANCH_NONE;
      br_tgt_q <= 32'd0;
      jr_tgt_q <= 32'd0;
      flush_q  <= 1'b0;
      busy_q   <= 1'b0;
      mis_q    <= 1'b0;
    end else if (!stall) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flush_q <= state_d == S_FLUSH;
      busy_q  <= state_d == S_FLUSH;
      taken_q <= redirect;
      type_q  <= redirect ? ex_branch_type : BRANCH_NONE;
      mis_q   <= mis;
      if (want) begin
        br_tgt_q <= br_tgt;
        jr_tgt_q <= jr_tgt;
      end
    end
  end

  assign branch_taken      = taken_q;
  assign branch_type       = type_q;
  assign branch_target     = br_tgt_q;
  assign jalr_target       = jr_tgt_q;
  assign flush             = flush_q;
  assign busy              = busy_q;
  assign target_misaligned = mis_q;

`ifdef BRANCH_PERF_CNT_EN
  logic [31:0] perf_br_q, perf_tk_q, perf_jp_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_br_q <= 32'd0;
      perf_tk_q <= 32'd0;
      perf_jp_q <= 32'd0;
    end else if (!stall && accept) begin
      if (ex_branch_type == BRANCH_COND) perf_br_q <= perf_br_q + 32'd1;
      if (ex_branch_type == BRANCH_COND && cond_true) perf_tk_q <= perf_tk_q + 32'd1;
      if (is_jump) perf_jp_q <= perf_jp_q + 32'd1;
    end
  end
  assign perf_branches = perf_br_q;
  assign perf_taken    = perf_tk_q;
  assign perf_jumps    = perf_jp_q;
`endif
endmodule

// File: doc/branch_unit.md
BRANCH_UNIT -- requirements
Module: branch_unit

Interface
REQ-001 The module SHALL have parameter FLUSH_CYCLES, default 2, giving the number of cycles wrong-path squash is held after a redirect (legal range 1..7).
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The module SHALL have port stall, input, 1 bit: pipeline hold; while high, no input is sampled and all state holds.
REQ-005 The module SHALL have ports ex_valid (1), ex_branch_type (branch_type_t), ex_branch_op (branch_op_t), ex_pc (32), ex_imm (32), rs1_data (32), rs2_data (32), all inputs: the EX-stage instruction.
REQ-006 The module SHALL have outputs branch_taken (1), branch_type (branch_type_t), branch_target (32) and jalr_target (32), all registered: the redirect interface to the program counter.
REQ-007 The module SHALL have outputs flush (1), target_misaligned (1) and busy (1), all registered.

Function
REQ-008 The module SHALL resolve BRANCH_COND as BEQ/BNE (rs1==rs2), BLT/BGE (signed compare) and BLTU/BGEU (unsigned compare) on ex_branch_op.
REQ-009 Target arithmetic SHALL be: branch_target = ex_pc + ex_imm, and jalr_target = (rs1_data + ex_imm) with bit 0 cleared; all sums are 32-bit modulo, wrap-around allowed.
REQ-010 A redirect SHALL be an accepted instruction (ex_valid=1, stall=0, state IDLE) that is JAL, JALR, or COND with the condition true.
REQ-011 Latency SHALL be one cycle: a redirect sampled at edge N drives branch_type, branch_taken=1 and both targets for exactly the cycle after edge N; all other cycles present branch_type=BRANCH_NONE and branch_taken=0.
REQ-012 A not-taken COND SHALL produce no redirect and no flush.
REQ-013 The FSM SHALL have states IDLE and FLUSH: a redirect moves IDLE->FLUSH and loads the counter with FLUSH_CYCLES; FLUSH decrements the counter on each non-stalled cycle and returns to IDLE when it reaches 0.
REQ-014 flush and busy SHALL be high exactly while the state is FLUSH.
REQ-015 While in FLUSH, ex_valid SHALL be ignored, since those instructions are wrong-path.
REQ-016 While stall is high, registered outputs SHALL hold their values, including a pending one-cycle redirect, which is presented for the first non-stalled cycle only.
REQ-017 If the selected target has bits [1:0] != 0, the module SHALL suppress the redirect, pulse target_misaligned for one cycle, and stay in IDLE.
REQ-018 Back-to-back redirects SHALL be impossible, because the second one arrives during FLUSH and is ignored.

Reset
REQ-019 When rst=1, the module SHALL go to state IDLE, clear the counter, and drive branch_taken=0, branch_type=BRANCH_NONE, both targets=0, and flush, busy and target_misaligned=0 on the next edge.
REQ-020 rst SHALL override stall, and a reset in mid-FLUSH SHALL abort the flush immediately.

Configuration
REQ-021 With BRANCH_PERF_CNT_EN defined, the module SHALL add 32-bit output counters perf_branches (accepted COND), perf_taken (taken COND) and perf_jumps (JAL/JALR), each wrapping at 2^32 and cleared by rst.
REQ-022 Without BRANCH_PERF_CNT_EN, the counters and their ports SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-023 branch_type_t (NONE/COND/JAL/JALR) and branch_op_t (funct3 encodings) SHALL live in riscvibe_pkg, which the module imports.
REQ-024 Condition evaluation SHALL be a combinational sub-module, branch_compare (rs1, rs2, op -> taken); the FSM, registers and counters stay in branch_unit.

Verification
REQ-025 BEQ with ex_pc=0x100, imm=0x20, rs1=rs2=5 -> next cycle branch_taken=1, branch_type=COND, branch_target=0x120, flush high for 2 cycles.
REQ-026 BLT with rs1=0xFFFFFFFF, rs2=1 -> taken; BLTU with the same operands -> not taken, and no flush.
REQ-027 JALR with rs1=0x2003, imm=0 -> jalr_target=0x2002 and target_misaligned=1, with no redirect; rs1=0x2001 -> jalr_target=0x2000 and redirect issued.
REQ-028 JAL at ex_pc=0xFFFFFFF0 with imm=0x20 -> branch_target=0x00000010 (wrap); a second JAL presented during FLUSH -> ignored.
REQ-029 Redirect with stall held high 3 cycles -> outputs hold, and the redirect appears only in the first non-stalled cycle; rst asserted mid-FLUSH -> all outputs at reset values on the next edge.
REQ-030 With BRANCH_PERF_CNT_EN defined, 3 taken and 2 not-taken COND plus 1 JAL (with flushes elapsing between them) -> perf_branches=5, perf_taken=3, perf_jumps=1.
